alu_io_responder: RTL and testbench

//  User-area responder for the dual-ALU pad protocol: samples the 20-bit operand/opcode

---
 rtl/alu_io_pkg.sv | 28 ++
 rtl/alu_io_responder_alu4_slice.sv | 34 +++
 rtl/alu_io_responder.sv | 136 +++++++++++++
 tb/tb_alu_io_responder.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_io_pkg.sv
// Shared definitions for the dual-ALU pad responder: op codes, FSM states,
// result field width and the bit positions of each operand inside in_vec.
package alu_io_pkg;

  localparam int FIELD_W = 7;
  localparam int VEC_W   = 20;
  localparam int RES_W   = 2 * FIELD_W + 1;

  localparam int A0_LSB   = 0;
  localparam int B0_LSB   = 4;
  localparam int A1_LSB   = 8;
  localparam int B1_LSB   = 12;
  localparam int SEL1_LSB = 16;
  localparam int SEL2_LSB = 18;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_AND = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    QUAL    = 2'd1,
    CALC    = 2'd2,
    PRESENT = 2'd3
  } state_t;

endpackage

// File: rtl/alu_io_responder_alu4_slice.sv
// One 4-bit ALU lane: combinational A,B,sel -> {zero, ovf, res[4:0]} field.
module alu4_slice
  import alu_io_pkg::*;
(
  input  logic [3:0]         a,
  input  logic [3:0]         b,
  input  logic [1:0]         sel,
  output logic [FIELD_W-1:0] field
);

  logic [4:0] res;
  logic       ovf;

  always_comb begin
    res = 5'd0;
    ovf = 1'b0;
    case (sel)
      OP_ADD: begin
        res = {1'b0, a} + {1'b0, b};
        ovf = res[4];
      end
      // 5-bit wrap keeps the borrow visible in res[4]; ovf flags the borrow
      OP_SUB: begin
        res = {1'b0, a} - {1'b0, b};
        ovf = (a < b);
      end
      OP_AND: res = {1'b0, a & b};
      OP_XOR: res = {1'b0, a ^ b};
      default: res = 5'd0;
    endcase
    field = {(res == 5'd0), ovf, res};
  end

endmodule

// File: rtl/alu_io_responder.sv
// Pad-side responder: synchronizes in_vec, waits for it to be stable, runs two
// ALU lanes and presents a packed result. Optional txn_count via ALU_TXN_CNT_EN.
module alu_io_responder
  import alu_io_pkg::*;
#(
  parameter int STABLE_CYCLES = 8,
  parameter int CNT_W         = 4
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic [19:0] in_vec,
  output logic [14:0] res_out,
  output logic [14:0] res_oeb,
  output logic        busy
`ifdef ALU_TXN_CNT_EN
  ,
  output logic [15:0] txn_count
`endif
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  state_t             state, state_nxt;
  logic [VEC_W-1:0]   sync1, sync_q, snap, committed;
  logic [CNT_W-1:0]   cnt;
  logic               primed;
  logic [FIELD_W-1:0] field1, field2, calc1_q, calc2_q, out1_q, out2_q;
  logic               valid_q;
  logic [14:0]        oeb_q;
  logic               snap_load, cnt_clr, cnt_inc, calc_en, present_en, valid_clr;

  alu4_slice u_alu1 (
    .a     (snap[A0_LSB +: 4]),
    .b     (snap[B0_LSB +: 4]),
    .sel   (snap[SEL1_LSB +: 2]),
    .field (field1)
  );

  alu4_slice u_alu2 (
    .a     (snap[A1_LSB +: 4]),
    .b     (snap[B1_LSB +: 4]),
    .sel   (snap[SEL2_LSB +: 2]),
    .field (field2)
  );

  always_comb begin
    state_nxt  = state;
    snap_load  = 1'b0;
    cnt_clr    = 1'b0;
    cnt_inc    = 1'b0;
    calc_en    = 1'b0;
    present_en = 1'b0;
    valid_clr  = 1'b0;
    case (state)
      // Unprimed forces one compute after reset even if the pads read as committed.
      IDLE: if (!primed || (sync_q != committed)) begin
        state_nxt = QUAL;
        snap_load = 1'b1;
        cnt_clr   = 1'b1;
        valid_clr = 1'b1;
      end
      QUAL: if (sync_q != snap) begin
        snap_load = 1'b1;
        cnt_clr   = 1'b1;
      end else if (cnt == CNT_LAST) begin
        state_nxt = CALC;
      end else begin
        cnt_inc = 1'b1;
      end
      CALC: begin
        calc_en   = 1'b1;
        state_nxt = PRESENT;
      end
      PRESENT: begin
        present_en = 1'b1;
        state_nxt  = IDLE;
      end
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state     <= IDLE;
      sync1     <= '0;
      sync_q    <= '0;
      snap      <= '0;
      committed <= '0;
      cnt       <= '0;
      primed    <= 1'b0;
      calc1_q   <= '0;
      calc2_q   <= '0;
      out1_q    <= '0;
      out2_q    <= '0;
      valid_q   <= 1'b0;
      oeb_q     <= 15'h7FFF;
    end else begin
      sync1  <= in_vec;
      sync_q <= sync1;
      state  <= state_nxt;
      oeb_q  <= 15'h0000;
      if (snap_load) snap <= sync_q;
      if (cnt_clr) cnt <= '0;
      else if (cnt_inc) cnt <= cnt + 1'b1;
      if (calc_en) begin
        committed <= snap;
        calc1_q   <= field1;
        calc2_q   <= field2;
      end
      // Data fields only move here, so dropping valid never glitches them.
      if (present_en) begin
        out1_q  <= calc1_q;
        out2_q  <= calc2_q;
        valid_q <= 1'b1;
        primed  <= 1'b1;
      end else if (valid_clr) begin
        valid_q <= 1'b0;
      end
    end
  end

`ifdef ALU_TXN_CNT_EN
  logic [15:0] txn_q;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) txn_q <= 16'h0000;
    else if (present_en) txn_q <= txn_q + 16'h0001;
  end

  assign txn_count = txn_q;
`endif

  assign res_out = {out2_q, out1_q, valid_q};
  assign res_oeb = oeb_q;
  assign busy    = (state == QUAL) || (state == CALC);

endmodule

// File: tb/tb_alu_io_responder.sv
// Randomized scoreboard bench for alu_io_responder; the ALU_TXN_CNT_EN
// checks compile in only when that macro is defined.
module tb_alu_io_responder;

  localparam int STABLE_CYCLES = 8;

  logic        wb_clk_i;
  logic        wb_rst_i;
  logic [19:0] in_vec;
  logic [14:0] res_out;
  logic [14:0] res_oeb;
  logic        busy;
`ifdef ALU_TXN_CNT_EN
  logic [15:0] txn_count;
`endif

  alu_io_responder #(.STABLE_CYCLES(STABLE_CYCLES), .CNT_W(4)) dut (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .in_vec   (in_vec),
    .res_out  (res_out),
    .res_oeb  (res_oeb),
    .busy     (busy)
`ifdef ALU_TXN_CNT_EN
    ,
    .txn_count(txn_count)
`endif
  );

  // clock / reset
  initial wb_clk_i = 1'b0;
  always #5 wb_clk_i = ~wb_clk_i;

  int total = 0;
  int bad   = 0;

  // scoreboard state
  logic [14:0] exp_q[$];
  logic [19:0] m_committed = '0;
  bit          m_primed = 1'b0;
  logic [15:0] m_txn = '0;
  logic [13:0] m_fields = '0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // reference model: plain arithmetic on the lane operands
  function automatic logic [6:0] ref_field(input int a, input int b, input int sel);
    int r;
    bit ovf;
    r = 0;
    ovf = 0;
    case (sel)
      0: begin r = a + b; ovf = (r >= 16); end
      1: begin r = (a - b + 32) % 32; ovf = (a < b); end
      2: r = a & b;
      default: r = a ^ b;
    endcase
    return {(r == 0), ovf, 5'(r)};
  endfunction

  function automatic logic [14:0] ref_result(input logic [19:0] v);
    logic [6:0] f1, f2;
    f1 = ref_field(int'(v[3:0]), int'(v[7:4]), int'(v[17:16]));
    f2 = ref_field(int'(v[11:8]), int'(v[15:12]), int'(v[19:18]));
    return {f2, f1, 1'b1};
  endfunction

  // a compute is expected whenever the held value departs from what was last committed
  function automatic void model_apply(input logic [19:0] v);
    if (!m_primed || (v != m_committed)) begin
      exp_q.push_back(ref_result(v));
      m_committed = v;
      m_primed    = 1'b1;
      m_txn       = m_txn + 16'd1;
    end
  endfunction

  function automatic void model_reset();
    exp_q.delete();
    m_committed = '0;
    m_primed    = 1'b0;
    m_txn       = '0;
  endfunction

  function automatic logic [19:0] rand_vec_diff();
    logic [19:0] v;
    do v = 20'($urandom()); while (v[19:1] == m_committed[19:1]);
    return v;
  endfunction

  // driver tasks
  task automatic hold_vec(input logic [19:0] v, input int cycles);
    @(negedge wb_clk_i);
    in_vec = v;
    model_apply(v);
    repeat (cycles) @(posedge wb_clk_i);
  endtask

  // applies v at a negedge (optionally releasing reset there) and measures the
  // number of rising edges, first sampling edge included, until valid is seen high
  task automatic timed_vec(input logic [19:0] v, input bit release_rst, input string name);
    int  edges;
    bit  seen_low;
    @(negedge wb_clk_i);
    in_vec = v;
    if (release_rst) wb_rst_i = 1'b0;
    model_apply(v);
    edges    = 0;
    seen_low = !res_out[0];
    while (edges < 40) begin
      @(posedge wb_clk_i);
      edges++;
      #1;
      if (release_rst && edges == 1) check({name, "_oeb_after_release"}, 32'(res_oeb), 32'h0);
      if (edges == 5) begin
        check({name, "_busy_qual"}, 32'(busy), 32'h1);
        check({name, "_valid_low_qual"}, 32'(res_out[0]), 32'h0);
      end
      if (!res_out[0]) seen_low = 1'b1;
      else if (seen_low) break;
    end
    check({name, "_latency"}, edges, STABLE_CYCLES + 5);
    repeat (3) @(posedge wb_clk_i);
  endtask

  // monitor: pops on every valid rise, checks field hold on every valid fall
  bit prev_valid = 1'b0;
  always @(negedge wb_clk_i) begin
    if (wb_rst_i) begin
      prev_valid = 1'b0;
    end else begin
      if (res_out[0] && !prev_valid) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_valid: got %0h expected no result at %0t", res_out, $time);
        end else begin
          logic [14:0] e;
          e = exp_q.pop_front();
          check("result", 32'(res_out), 32'(e));
          m_fields = e[14:1];
        end
      end else if (!res_out[0] && prev_valid) begin
        check("fields_hold_on_drop", 32'(res_out[14:1]), 32'(m_fields));
      end
      prev_valid = res_out[0];
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [19:0] v, vb;

    // reset state
    wb_rst_i = 1'b1;
    in_vec   = {2'b00, 2'b00, 4'h0, 4'h0, 4'h9, 4'h9};
    repeat (3) @(posedge wb_clk_i);
    #1;
    check("reset_res_out", 32'(res_out), 32'h0);
    check("reset_res_oeb", 32'(res_oeb), 32'h7FFF);
    check("reset_busy", 32'(busy), 32'h0);

    // 1: 9+9 / 0+0, latency measured from reset release
    timed_vec({2'b00, 2'b00, 4'h0, 4'h0, 4'h9, 4'h9}, 1'b1, "t1");
    check("t1_exact", 32'(res_out), 32'(15'b1000000_0110010_1));

    // 2: 3-5 and F^F
    timed_vec({2'b11, 2'b01, 4'hF, 4'hF, 4'h5, 4'h3}, 1'b0, "t2");
    check("t2_exact", 32'(res_out), 32'({7'b1000000, 7'b0111110, 1'b1}));

    // 3: bit0 toggling every 3 clocks never qualifies
    v = rand_vec_diff();
    for (int k = 0; k < 12; k++) begin
      @(negedge wb_clk_i);
      in_vec = v ^ 20'(k % 2);
      repeat (3) @(posedge wb_clk_i);
      #1;
      if (k >= 2 && (k % 4) == 2) begin
        check("t3_busy", 32'(busy), 32'h1);
        check("t3_valid_low", 32'(res_out[0]), 32'h0);
        check("t3_fields", 32'(res_out[14:1]), 32'(m_fields));
      end
    end
    timed_vec(v, 1'b0, "t3_settle");

    // 4: reset during QUAL, then the same vector is recomputed
    v = rand_vec_diff();
    hold_vec(v, 6);
    #3 wb_rst_i = 1'b1;
    #1;
    check("t4_rst_res_out", 32'(res_out), 32'h0);
    check("t4_rst_res_oeb", 32'(res_oeb), 32'h7FFF);
    check("t4_rst_busy", 32'(busy), 32'h0);
    model_reset();
    repeat (2) @(posedge wb_clk_i);
    timed_vec(v, 1'b1, "t4_recompute");

    // 5: depart and return within QUAL; same result presented again
    vb = rand_vec_diff();
    @(negedge wb_clk_i);
    in_vec = vb;
    repeat (5) @(posedge wb_clk_i);
    #1;
    check("t5_valid_drop", 32'(res_out[0]), 32'h0);
    @(negedge wb_clk_i);
    in_vec = v;
    exp_q.push_back(ref_result(v));
    m_txn = m_txn + 16'd1;
    repeat (20) @(posedge wb_clk_i);
    #1;
    check("t5_valid_back", 32'(res_out[0]), 32'h1);
`ifdef ALU_TXN_CNT_EN
    check("t5_txn_count", 32'(txn_count), 32'(m_txn));
`endif

    // random vectors held long enough to qualify
    for (int n = 0; n < 12; n++) begin
      v = 20'($urandom());
      hold_vec(v, $urandom_range(16, 22));
    end

`ifdef ALU_TXN_CNT_EN
    // 6: counter wraps from 0xFFFF
    check("t6_txn_before", 32'(txn_count), 32'(m_txn));
    @(negedge wb_clk_i);
    force dut.txn_q = 16'hFFFF;
    #1 release dut.txn_q;
    m_txn = 16'hFFFF;
    hold_vec(rand_vec_diff(), 20);
    #1;
    check("t6_txn_wrap", 32'(txn_count), 32'(m_txn));
`endif

    repeat (5) @(posedge wb_clk_i);
    #1;
    check("drain", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
